posit_add_normalise: RTL and testbench
======================================

// Module: posit_add_normalise
// PURPOSE
//  Pipelined normalisation stage of the posit adder, directly downstream of the leading-one detector.
//  Consumes three inputs:
//   - the raw mantissa sum;
//   - the LOD leading-zero count;
//   - the LOD all-zero flag.
//  Left-shifts the mantissa so the hidden bit lands in the MSB and corrects the scale (regime+exponent).
//  Output feeds the posit encode/round stage. Two register stages; valid/ready on both sides.
// PARAMETERS
//  N   8          posit word width
//  es  4          exponent field width
//  Bs  log2(N)    LOD count width minus 1; count port is Bs+1 bits
//  M   N-es+3     mantissa sum width; bit M-1 is the carry position
//  SW  es+Bs+2    signed scale width (two's complement)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     synchronous, active-high
//  in_valid   in   1     input beat valid
//  in_ready   out  1     stage can accept a beat
//  in_sign    in   1     result sign from adder
//  in_mant    in   M     unsigned mantissa sum, MSB = carry bit
//  in_count   in   Bs+1  LOD leading-zero count of in_mant
//  in_zero    in   1     LOD all-zero flag (in_mant == 0)
//  in_scale   in   SW    signed scale of larger operand
//  out_valid  out  1     output beat valid
//  out_ready  in   1     downstream accepts beat
//  out_sign   out  1     registered sign
//  out_mant   out  M     normalised mantissa, out_mant[M-1]=1 unless out_zero
//  out_scale  out  SW    corrected, saturated scale
//  out_zero   out  1     result is exact zero
//  out_ovf    out  1     scale saturated at max
//  out_unf    out  1     scale saturated at min
// BEHAVIOUR
//  - Reset: s1_valid, s2_valid = 0. All data outputs = 0; out_valid = 0, in_ready = 1 after reset.
//  - Stage 1: capture inputs when in_valid & in_ready. Compute:
//     - eff_zero = in_zero | (in_count >= M);
//     - scale_ext = sext(in_scale, SW+1) + 1 - in_count  (SW+1 bits, no wrap).
//  - Stage 2: capture from stage 1.
//     - mant = s1_mant << s1_count; zeros shifted in at LSB.
//     - Saturate scale: scale_ext > 2^(SW-1)-1 -> max, out_ovf=1; scale_ext < -2^(SW-1) -> min, out_unf=1.
//  - eff_zero beat: out_mant=0, out_scale=0, out_zero=1, out_ovf=out_unf=0; sign passes through unchanged.
//  - Flow control:
//     - s2 advances when ~s2_valid | out_ready;
//     - s1 advances when ~s1_valid | s2 advance;
//     - in_ready = ~s1_valid | s2_advance.
//     - in_ready is combinational from out_ready (no skid buffer).
//  - Latency: 2 cycles from input accept to out_valid when unstalled. Throughput 1 beat/cycle.
//  - Output hold: while out_valid & ~out_ready, all out_* hold stable and no beat is lost or duplicated.
//  - Simultaneous accept at input and drain at output in one cycle is legal; occupancy unchanged.
//  - Reset mid-stall: both valids clear next edge; in-flight beats are discarded.
//  - No internal FSM beyond two valid bits: EMPTY, ONE(s1 or s2), FULL. Order strictly FIFO.
// TESTING  (N=8, es=4 -> M=7, SW=9)
//  1. mant=7'b1000000, count=0, scale=5 -> 2 cycles later mant=7'b1000000, scale=6, flags 0.
//  2. mant=7'b0010110, count=2, scale=5 -> mant=7'b1011000, scale=4.
//  3. in_zero=1, sign=1, scale=17 -> out_zero=1, mant=0, scale=0, sign=1.
//  4. scale=255, count=0 -> scale=255, out_ovf=1; scale=-256, count=6 -> scale=-256, out_unf=1.
//  5. Stream 6 beats, out_ready=0 for cycles 3-6:
//      - in_ready drops once 2 beats are held;
//      - outputs stay stable;
//      - all 6 beats emerge in order.
//  6. Assert reset while FULL and stalled -> next cycle out_valid=0, in_ready=1, outputs 0; fresh beat latency 2.

Source files
------------

// File: rtl/posit_add_normalise.sv
// Posit adder normalisation stage: shifts the mantissa sum so its leading one sits in the
// MSB and corrects and saturates the scale. Two register stages with valid/ready on both sides.
module posit_add_normalise #(
  parameter int N  = 8,
  parameter int es = 4,
  parameter int Bs = $clog2(N),
  parameter int M  = N - es + 3,
  parameter int SW = es + Bs + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [M-1:0]         in_mant,
  input  logic [Bs:0]          in_count,
  input  logic                 in_zero,
  input  logic signed [SW-1:0] in_scale,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic [M-1:0]         out_mant,
  output logic signed [SW-1:0] out_scale,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_unf
);

  localparam int SE   = SW + 1;
  localparam int MAXI = 2 ** (SW - 1) - 1;
  localparam int MINI = -(2 ** (SW - 1));

  logic                 s1_valid;
  logic                 s1_sign;
  logic                 s1_zero;
  logic [M-1:0]         s1_mant;
  logic [Bs:0]          s1_count;
  logic signed [SE-1:0] s1_scale;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 eff_zero;
  logic [SE-1:0]        scale_ext;
  logic [M-1:0]         mant_shift;

  assign s2_adv    = ~out_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;

  // A count at or beyond the mantissa width can only mean the sum vanished.
  assign eff_zero   = in_zero | (32'(in_count) >= M);
  // One extra bit of headroom so the +1 carry correction and the count subtraction never wrap.
  assign scale_ext  = {in_scale[SW-1], in_scale} + SE'(1) - SE'(in_count);
  assign mant_shift = s1_mant << s1_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_mant   <= '0;
      s1_count  <= '0;
      s1_scale  <= '0;
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_mant  <= '0;
      out_scale <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign  <= in_sign;
          s1_zero  <= eff_zero;
          s1_mant  <= in_mant;
          s1_count <= in_count;
          s1_scale <= $signed(scale_ext);
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_sign <= s1_sign;
          if (s1_zero) begin
            out_mant  <= '0;
            out_scale <= '0;
            out_zero  <= 1'b1;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
          end else begin
            out_mant <= mant_shift;
            out_zero <= 1'b0;
            if (s1_scale > $signed(SE'(MAXI))) begin
              out_scale <= SW'(MAXI);
              out_ovf   <= 1'b1;
              out_unf   <= 1'b0;
            end else if (s1_scale < $signed(SE'(MINI))) begin
              out_scale <= SW'(MINI);
              out_ovf   <= 1'b0;
              out_unf   <= 1'b1;
            end else begin
              out_scale <= s1_scale[SW-1:0];
              out_ovf   <= 1'b0;
              out_unf   <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_add_normalise.sv
// Bench for posit_add_normalise: directed corner beats, stall/reset scenarios and random traffic
// scored against an integer-arithmetic model through an in-order expectation queue.
module tb_posit_add_normalise;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [6:0]        in_mant;
  logic [3:0]        in_count;
  logic              in_zero;
  logic signed [8:0] in_scale;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [6:0]        out_mant;
  logic signed [8:0] out_scale;
  logic              out_zero;
  logic              out_ovf;
  logic              out_unf;

  // {sign, mant, scale, zero, ovf, unf}
  typedef logic [19:0] exp_t;
  typedef struct {
    exp_t e;
    int   acc;
    bit   lat2;
  } item_t;

  item_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    occ = 0;
  int    n_out = 0;
  bit    prev_stall = 0;
  logic [20:0] prev_out;
  bit    last_fire_in;
  bit    last_in_ready;

  posit_add_normalise dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign), .in_mant(in_mant),
    .in_count(in_count), .in_zero(in_zero), .in_scale(in_scale),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_mant(out_mant),
    .out_scale(out_scale), .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the posit normalisation rules.
  function automatic exp_t model(input logic s, input logic [6:0] m, input logic [3:0] c,
                                 input logic z, input logic signed [8:0] sc);
    int v;
    int mm;
    exp_t r;
    if (z || c >= 7) begin
      r = {s, 7'd0, 9'd0, 3'b100};
      return r;
    end
    v  = int'(sc) + 1 - int'(c);
    mm = (int'(m) * (1 << c)) % 128;
    if (v > 255)       r = {s, mm[6:0], 9'd255, 3'b010};
    else if (v < -256) r = {s, mm[6:0], 9'h100, 3'b001};
    else               r = {s, mm[6:0], v[8:0], 3'b000};
    return r;
  endfunction

  function automatic logic [20:0] outs();
    return {out_valid, out_sign, out_mant, out_scale, out_zero, out_ovf, out_unf};
  endfunction

  // One clock cycle: apply handshake, check, score, then advance.
  task automatic step(input logic v, input logic rdy, input exp_t e, input bit lat2);
    item_t it;
    in_valid  = v;
    out_ready = rdy;
    #1;
    if (prev_stall) chk("hold", 32'(outs()), 32'(prev_out));
    chk("in_ready", 32'(in_ready), 32'((occ < 2) || rdy));
    if (out_valid && rdy) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        it = q.pop_front();
        chk("beat", 32'({out_sign, out_mant, out_scale, out_zero, out_ovf, out_unf}), 32'(it.e));
        if (it.lat2) chk("latency", 32'(cyc - it.acc), 32'(2));
        else         chk("latency_min", 32'(cyc - it.acc >= 2), 32'(1));
        n_out++;
        occ--;
      end
    end
    last_in_ready = in_ready;
    last_fire_in  = v && in_ready;
    if (last_fire_in) begin
      q.push_back('{e: e, acc: cyc, lat2: lat2});
      occ++;
    end
    prev_stall = out_valid && !rdy;
    prev_out   = outs();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_in(input logic s, input logic [6:0] m, input logic [3:0] c,
                        input logic z, input logic signed [8:0] sc);
    in_sign = s; in_mant = m; in_count = c; in_zero = z; in_scale = sc;
  endtask

  task automatic rand_inputs();
    logic [6:0] m;
    m = 7'($urandom_range(0, 127));
    set_in(1'($urandom), m, 4'($urandom_range(0, 8)),
           ($urandom_range(0, 7) == 0) || (m == 0), 9'(int'($urandom_range(0, 511)) - 256));
  endtask

  task automatic directed(input string tag, input exp_t e);
    step(1'b1, 1'b1, e, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    chk(tag, 32'(q.size()), 32'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 1'b1, '0, 1'b0);
    chk("drain", 32'(q.size()), 32'(0));
  endtask

  initial begin
    int sent;
    int base;
    bit have;
    bit saw_low;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 7'd0, 4'd0, 1'b0, 9'sd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_out", 32'(outs()), 32'(0));
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);

    // Directed corner beats
    set_in(1'b0, 7'b1000000, 4'd0, 1'b0, 9'sd5);
    directed("t1", {1'b0, 7'b1000000, 9'd6, 3'b000});
    set_in(1'b0, 7'b0010110, 4'd2, 1'b0, 9'sd5);
    directed("t2", {1'b0, 7'b1011000, 9'd4, 3'b000});
    set_in(1'b1, 7'b0000000, 4'd7, 1'b1, 9'sd17);
    directed("t3", {1'b1, 7'd0, 9'd0, 3'b100});
    set_in(1'b0, 7'b1000000, 4'd0, 1'b0, 9'sd255);
    directed("t4_ovf", {1'b0, 7'b1000000, 9'd255, 3'b010});
    set_in(1'b0, 7'b0000001, 4'd6, 1'b0, -9'sd256);
    directed("t4_unf", {1'b0, 7'b1000000, 9'h100, 3'b001});
    set_in(1'b0, 7'b0000011, 4'd7, 1'b0, 9'sd3);
    directed("count_ge_m", {1'b0, 7'd0, 9'd0, 3'b100});

    // Six-beat stream with a four-cycle output stall
    sent = 0; have = 0; saw_low = 0; base = n_out;
    for (int k = 0; k < 40 && (sent < 6 || q.size() > 0); k++) begin
      if (sent < 6 && !have) begin
        rand_inputs();
        have = 1;
      end
      step(sent < 6, !(k >= 3 && k <= 6),
           model(in_sign, in_mant, in_count, in_zero, in_scale), 1'b0);
      if (!last_in_ready) saw_low = 1;
      if (last_fire_in) begin
        sent++;
        have = 0;
      end
    end
    chk("s5_inready_drop", 32'(saw_low), 32'(1));
    chk("s5_count", 32'(n_out - base), 32'(6));

    // Reset while full and stalled
    for (int k = 0; k < 3; k++) begin
      rand_inputs();
      step(1'b1, 1'b0, model(in_sign, in_mant, in_count, in_zero, in_scale), 1'b0);
    end
    chk("s6_full", 32'(occ), 32'(2));
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    chk("s6_out", 32'(outs()), 32'(0));
    chk("s6_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    occ = 0;
    prev_stall = 0;
    set_in(1'b1, 7'b0101000, 4'd1, 1'b0, -9'sd10);
    directed("s6_fresh", {1'b1, 7'b1010000, 9'h1F6, 3'b000});

    // Random traffic with random back-pressure
    for (int k = 0; k < 300; k++) begin
      rand_inputs();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           model(in_sign, in_mant, in_count, in_zero, in_scale), 1'b0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
